// File: rtl/ct_spsram_param_taint_if.sv
// Bus bundle for the tainted single-port SRAM: access controls, their taint
// shadows, and the read data / read taint returned by the memory.
interface ct_spsram_param_taint_if #(
    parameter int ADDR_WIDTH = 13,
    parameter int DATA_WIDTH = 128,
    parameter int WE_WIDTH   = 128
);
    logic [ADDR_WIDTH-1:0] A;
    logic [ADDR_WIDTH-1:0] A_t0;
    logic                  CEN;
    logic                  CEN_t0;
    logic                  GWEN;
    logic                  GWEN_t0;
    logic [DATA_WIDTH-1:0] D;
    logic [DATA_WIDTH-1:0] D_t0;
    logic [WE_WIDTH-1:0]   WEN;
    logic [WE_WIDTH-1:0]   WEN_t0;
    logic [DATA_WIDTH-1:0] Q;
    logic [DATA_WIDTH-1:0] Q_t0;
    logic                  INIT_BUSY;
    logic                  dbg_ready;

    // Access protocol: no valid/ready pair. An access is the set of request
    // signals sampled at a posedge with CEN=0 while INIT_BUSY=0; requests seen
    // while INIT_BUSY=1 are silently dropped. Read data/taint return on Q/Q_t0
    // one cycle later (two with the output pipe) and hold until the next read.
    modport master (
        output A, A_t0, CEN, CEN_t0, GWEN, GWEN_t0, D, D_t0, WEN, WEN_t0,
        input  Q, Q_t0, INIT_BUSY, dbg_ready
    );

    modport slave (
        input  A, A_t0, CEN, CEN_t0, GWEN, GWEN_t0, D, D_t0, WEN, WEN_t0,
        output Q, Q_t0, INIT_BUSY, dbg_ready
    );
endinterface

// File: rtl/ct_spsram_param_taint.sv
// Parametrised single-port SRAM with a per-bit taint shadow array, a post-reset
// shadow clearing sequence, sticky address-taint tracking and optional output pipe.
module ct_spsram_param_taint #(
    parameter int ADDR_WIDTH = 13,
    parameter int DATA_WIDTH = 128,
    parameter int WE_WIDTH   = 128,
    parameter int RD_PIPE    = 0
) (
    input logic                       CLK,
    input logic                       RST,
    ct_spsram_param_taint_if.slave    bus
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int G     = DATA_WIDTH / WE_WIDTH;

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;
    logic                  sticky_q, sticky_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic [DATA_WIDTH-1:0] rd_taint_q, rd_taint_d;

    logic [DATA_WIDTH-1:0] mem    [DEPTH];
    logic [DATA_WIDTH-1:0] shadow [DEPTH];

    logic acc_en;
    logic wr_fire;
    logic rd_en;
    logic clr_fire;
    logic ctl_t;

    // Accesses only count in READY; during INIT chip enable is forced off.
    always_comb begin
        acc_en   = (state_q == ST_READY) && !bus.CEN;
        wr_fire  = acc_en && !bus.GWEN && !RST;
        rd_en    = acc_en && bus.GWEN;
        clr_fire = (state_q == ST_INIT) && !RST;
        ctl_t    = bus.CEN_t0 | bus.GWEN_t0 | (|bus.A_t0);
    end

    always_comb begin
        state_d    = state_q;
        clr_cnt_d  = clr_cnt_q;
        sticky_d   = sticky_q;
        rd_data_d  = rd_data_q;
        rd_taint_d = rd_taint_q;

        if (state_q == ST_INIT) begin
            clr_cnt_d = clr_cnt_q + ADDR_WIDTH'(1);
            if (clr_cnt_q == {ADDR_WIDTH{1'b1}}) begin
                state_d = ST_READY;
            end
        end

        // A write through a tainted address may have hit any row.
        if (acc_en && !bus.GWEN && (|bus.A_t0)) begin
            sticky_d = 1'b1;
        end

        if (rd_en) begin
            rd_data_d  = mem[bus.A];
            rd_taint_d = shadow[bus.A] | {DATA_WIDTH{ctl_t | sticky_q}};
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= ST_INIT;
            clr_cnt_q  <= '0;
            sticky_q   <= 1'b0;
            rd_data_q  <= '0;
            rd_taint_q <= '0;
        end else begin
            state_q    <= state_d;
            clr_cnt_q  <= clr_cnt_d;
            sticky_q   <= sticky_d;
            rd_data_q  <= rd_data_d;
            rd_taint_q <= rd_taint_d;
        end
    end

    // Data array is never reset; only the shadow is scrubbed after reset.
    always_ff @(posedge CLK) begin
        if (wr_fire) begin
            for (int g = 0; g < WE_WIDTH; g++) begin
                if (!bus.WEN[g]) begin
                    mem[bus.A][g*G +: G] <= bus.D[g*G +: G];
                end
            end
        end
    end

    // A tainted but deasserted group enable may still have written: poison it.
    always_ff @(posedge CLK) begin
        if (clr_fire) begin
            shadow[clr_cnt_q] <= '0;
        end else if (wr_fire) begin
            for (int g = 0; g < WE_WIDTH; g++) begin
                if (!bus.WEN[g]) begin
                    shadow[bus.A][g*G +: G] <= bus.D_t0[g*G +: G] | {G{ctl_t | bus.WEN_t0[g]}};
                end else if (bus.WEN_t0[g]) begin
                    shadow[bus.A][g*G +: G] <= {G{1'b1}};
                end
            end
        end
    end

    generate
        if (RD_PIPE != 0) begin : g_pipe
            logic [DATA_WIDTH-1:0] pipe_data_q, pipe_data_d;
            logic [DATA_WIDTH-1:0] pipe_taint_q, pipe_taint_d;

            always_comb begin
                pipe_data_d  = rd_data_q;
                pipe_taint_d = rd_taint_q;
            end

            always_ff @(posedge CLK) begin
                if (RST) begin
                    pipe_data_q  <= '0;
                    pipe_taint_q <= '0;
                end else begin
                    pipe_data_q  <= pipe_data_d;
                    pipe_taint_q <= pipe_taint_d;
                end
            end

            assign bus.Q    = pipe_data_q;
            assign bus.Q_t0 = pipe_taint_q;
        end else begin : g_nopipe
            assign bus.Q    = rd_data_q;
            assign bus.Q_t0 = rd_taint_q;
        end
    endgenerate

    assign bus.INIT_BUSY = (state_q == ST_INIT);
    assign bus.dbg_ready = (state_q == ST_READY);

endmodule
